// File: rtl/ram_bit_seq.sv
// Command sequencer for the 3-port bit RAM: read two operand bits, compute a
// one-bit result, write it back; also sweeps the whole RAM to zero on request.
//
// state | meaning
// IDLE  | waiting for clr_start or a command; cmd_ready high unless clr_start
// READ  | operand addresses driven, RAM outputs captured at the end
// EXEC  | result driven on port C, single write strobe (none for TST)
// CLEAR | one zero write per cycle, address 0 up to 2**AWIDTH-1
module ram_bit_seq #(
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [AWIDTH-1:0] cmd_addr_a,
    input  logic [AWIDTH-1:0] cmd_addr_b,
    input  logic [AWIDTH-1:0] cmd_addr_d,
    input  logic              clr_start,
    output logic              busy,
    output logic              done,
    output logic              result,
    output logic [AWIDTH-1:0] ram_a_address,
    input  logic              ram_a_out,
    output logic [AWIDTH-1:0] ram_b_address,
    input  logic              ram_b_out,
    output logic [AWIDTH-1:0] ram_c_address,
    output logic              ram_c_data,
    output logic              ram_c_we
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, CLEAR} state_t;

    localparam logic [2:0] OP_MOV = 3'd0;
    localparam logic [2:0] OP_NOT = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SET = 3'd5;
    localparam logic [2:0] OP_CLR = 3'd6;
    localparam logic [2:0] OP_TST = 3'd7;

    localparam logic [AWIDTH:0] CNT_ONE  = 1;
    localparam logic [AWIDTH:0] CNT_LAST = {1'b0, {AWIDTH{1'b1}}};

    state_t            state_q;
    logic [2:0]        op_q;
    logic [AWIDTH-1:0] addr_a_q;
    logic [AWIDTH-1:0] addr_b_q;
    logic [AWIDTH-1:0] addr_d_q;
    logic [AWIDTH-1:0] c_addr_q;
    logic [AWIDTH:0]   cnt_q;
    logic [AWIDTH:0]   cnt_d;
    logic              opa_q;
    logic              opb_q;
    logic              we_q;
    logic              done_q;
    logic              result_q;
    logic              r_d;

    always_comb begin
        r_d = opa_q;
        case (op_q)
            OP_MOV:  r_d = opa_q;
            OP_NOT:  r_d = ~opa_q;
            OP_AND:  r_d = opa_q & opb_q;
            OP_OR:   r_d = opa_q | opb_q;
            OP_XOR:  r_d = opa_q ^ opb_q;
            OP_SET:  r_d = 1'b1;
            OP_CLR:  r_d = 1'b0;
            default: r_d = opa_q;
        endcase
    end

    assign cnt_d = cnt_q + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MOV;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_d_q <= '0;
            c_addr_q <= '0;
            cnt_q    <= '0;
            opa_q    <= 1'b0;
            opb_q    <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    we_q <= 1'b0;
                    if (clr_start) begin
                        state_q  <= CLEAR;
                        cnt_q    <= '0;
                        c_addr_q <= '0;
                        we_q     <= 1'b1;
                    end else if (cmd_valid) begin
                        op_q     <= cmd_op;
                        addr_a_q <= cmd_addr_a;
                        addr_b_q <= cmd_addr_b;
                        addr_d_q <= cmd_addr_d;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    opa_q    <= ram_a_out;
                    opb_q    <= ram_b_out;
                    c_addr_q <= addr_d_q;
                    we_q     <= (op_q != OP_TST);
                    state_q  <= EXEC;
                end
                EXEC: begin
                    result_q <= r_d;
                    done_q   <= 1'b1;
                    we_q     <= 1'b0;
                    state_q  <= IDLE;
                end
                CLEAR: begin
                    // Exit only after the last address has been written.
                    cnt_q    <= cnt_d;
                    c_addr_q <= cnt_d[AWIDTH-1:0];
                    if (cnt_q == CNT_LAST) begin
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = (state_q == IDLE) && !clr_start;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign result        = result_q;
    assign ram_a_address = addr_a_q;
    assign ram_b_address = addr_b_q;
    assign ram_c_address = c_addr_q;
    assign ram_c_data    = (state_q == EXEC) ? r_d : 1'b0;
    assign ram_c_we      = we_q;

endmodule

// File: tb/tb_ram_bit_seq.sv
// Bench for ram_bit_seq: behavioural bit RAM, result scoreboard, opcode table
// and directed sequences for clear, back-to-back, self-reference and reset.
module tb_ram_bit_seq;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_addr_a = '0;
    logic [AW-1:0] cmd_addr_b = '0;
    logic [AW-1:0] cmd_addr_d = '0;
    logic          clr_start = 1'b0;
    logic          busy, done, result;
    logic [AW-1:0] ram_a_address, ram_b_address, ram_c_address;
    logic          ram_a_out, ram_b_out, ram_c_data, ram_c_we;

    ram_bit_seq #(.AWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_addr_d(cmd_addr_d),
        .clr_start(clr_start), .busy(busy), .done(done), .result(result),
        .ram_a_address(ram_a_address), .ram_a_out(ram_a_out),
        .ram_b_address(ram_b_address), .ram_b_out(ram_b_out),
        .ram_c_address(ram_c_address), .ram_c_data(ram_c_data), .ram_c_we(ram_c_we)
    );

    always #5 clk = ~clk;

    // Bit RAM with combinational reads; fill presets every cell to 1.
    logic mem [DEPTH];
    logic fill = 1'b0;
    assign ram_a_out = mem[ram_a_address];
    assign ram_b_out = mem[ram_b_address];

    int we_cnt  = 0;
    int acc_cnt = 0;
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 1'b1;
        end else if (ram_c_we) begin
            mem[ram_c_address] <= ram_c_data;
        end
        if (ram_c_we) we_cnt <= we_cnt + 1;
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    logic sb_q[$];

    always @(negedge clk) begin
        if (done) begin
            check("done_has_expected_entry", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) check("result_at_done", result, sb_q.pop_front());
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        check({nm, "_done"}, done, 1);
    endtask

    task automatic run_cmd(input string nm, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                           input logic exp_r, input int exp_we);
        int n = 0;
        int we0;
        @(negedge clk);
        cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_addr_d = d; cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ready"}, cmd_ready, 1);
        we0 = we_cnt;
        @(posedge clk);
        sb_q.push_back(exp_r);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(nm);
        check({nm, "_we_count"}, we_cnt - we0, exp_we);
        if (exp_we != 0) check({nm, "_mem"}, mem[d], exp_r);
    endtask

    task automatic run_clear(input logic exp_res);
        int bad = 0;
        @(negedge clk);
        clr_start = 1'b1;
        #1;
        check("clr_ready_low", cmd_ready, 0);
        @(posedge clk);
        sb_q.push_back(exp_res);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == 3) clr_start = 1'b0;
            if (!ram_c_we || ram_c_address != i[7:0] || !busy || done || ram_c_data) bad++;
        end
        check("clr_sweep_errors", bad, 0);
        @(negedge clk);
        check("clr_done", done, 1);
        check("clr_busy_end", busy, 0);
        check("clr_we_end", ram_c_we, 0);
        @(negedge clk);
        check("clr_done_single", done, 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 1'b0) bad++;
        check("clr_mem_nonzero", bad, 0);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a, b, d;
        logic       exp_r;
        int         exp_we;
    } vec_t;
    vec_t vt[12];

    initial begin
        int n, a0, t0, t1, bad_lo, bad_hi;

        vt[0]  = '{3'd5, 8'h00, 8'h00, 8'h10, 1'b1, 1};
        vt[1]  = '{3'd6, 8'h00, 8'h00, 8'h11, 1'b0, 1};
        vt[2]  = '{3'd0, 8'h10, 8'h11, 8'h20, 1'b1, 1};
        vt[3]  = '{3'd1, 8'h10, 8'h11, 8'h21, 1'b0, 1};
        vt[4]  = '{3'd2, 8'h10, 8'h11, 8'h22, 1'b0, 1};
        vt[5]  = '{3'd3, 8'h10, 8'h11, 8'h23, 1'b1, 1};
        vt[6]  = '{3'd4, 8'h10, 8'h11, 8'h24, 1'b1, 1};
        vt[7]  = '{3'd7, 8'h20, 8'h00, 8'h11, 1'b1, 0};
        vt[8]  = '{3'd4, 8'h10, 8'h10, 8'h26, 1'b0, 1};
        vt[9]  = '{3'd2, 8'h10, 8'h20, 8'h27, 1'b1, 1};
        vt[10] = '{3'd1, 8'h11, 8'h00, 8'h28, 1'b1, 1};
        vt[11] = '{3'd3, 8'h11, 8'h22, 8'h29, 1'b0, 1};

        #2 rst = 1'b1;
        fill = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_we", ram_c_we, 0);
        check("rst_c_addr", ram_c_address, 0);
        check("rst_a_addr", ram_a_address, 0);
        check("rst_c_data", ram_c_data, 0);
        repeat (2) @(negedge clk);
        fill = 1'b0;
        rst  = 1'b0;
        #1;
        check("rst_ready", cmd_ready, 1);

        run_clear(1'b0);

        for (int i = 0; i < 12; i++)
            run_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].d,
                    vt[i].exp_r, vt[i].exp_we);
        check("tst_no_write", mem[8'h11], 0);

        // Back-to-back: second command held valid while the first runs.
        @(negedge clk);
        cmd_op = 3'd5; cmd_addr_d = 8'h05; cmd_valid = 1'b1;
        @(posedge clk);
        t0 = $rtoi($time);
        sb_q.push_back(1'b1);
        @(negedge clk);
        cmd_op = 3'd0; cmd_addr_a = 8'h05; cmd_addr_d = 8'h06;
        n = 0;
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        t1 = $rtoi($time);
        sb_q.push_back(1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_spacing_cycles", (t1 - t0) / 10, 3);
        wait_done("b2b");
        check("b2b_mem06", mem[8'h06], 1);

        // Self-reference: destination equals operand.
        run_cmd("selfref0", 3'd1, 8'h30, 8'h00, 8'h30, 1'b1, 1);
        run_cmd("selfref1", 3'd1, 8'h30, 8'h00, 8'h30, 1'b0, 1);
        run_cmd("selfref2", 3'd1, 8'h30, 8'h00, 8'h30, 1'b1, 1);
        check("selfref_mem30", mem[8'h30], 1);

        // Clear and command requested together: clear wins.
        @(negedge clk);
        cmd_op = 3'd5; cmd_addr_d = 8'h40; cmd_valid = 1'b1; clr_start = 1'b1;
        #1;
        check("prio_ready_low", cmd_ready, 0);
        a0 = acc_cnt;
        @(posedge clk);
        sb_q.push_back(1'b1);
        @(negedge clk);
        clr_start = 1'b0;
        check("prio_busy", busy, 1);
        check("prio_ready_busy", cmd_ready, 0);
        n = 1;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("prio_clear_len", n, 257);
        check("prio_no_accept", acc_cnt - a0, 0);
        check("prio_ready_after", cmd_ready, 1);
        @(posedge clk);
        sb_q.push_back(1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("prio_accept", acc_cnt - a0, 1);
        wait_done("prio_cmd");
        check("prio_mem40", mem[8'h40], 1);

        // Reset in the middle of a clear.
        @(negedge clk);
        fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        clr_start = 1'b1;
        @(posedge clk);
        sb_q.push_back(1'b1);
        @(negedge clk);
        clr_start = 1'b0;
        for (int i = 0; i < 128; i++) @(negedge clk);
        check("midrst_addr", ram_c_address, 8'h80);
        rst = 1'b1;
        #1;
        check("midrst_we", ram_c_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready", cmd_ready, 1);
        check("midrst_result", result, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("midrst_no_done", n, 0);
        bad_lo = 0;
        bad_hi = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== 1'b0) bad_lo++;
        for (int i = 128; i < DEPTH; i++) if (mem[i] !== 1'b1) bad_hi++;
        check("midrst_low_cleared", bad_lo, 0);
        check("midrst_high_kept", bad_hi, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
